// File: rtl/rv32_pkg.sv
// Shared RV32I core constants and the fetch buffer entry type.
package rv32_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
   localparam int FETCH_BUF_DEPTH_DEF = 2;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] word;
   } fetch_entry_t;

   // Sequential PC step; wraps modulo 2^32.
   function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous {pc, word} FIFO with flush, registered head entry and occupancy count.
module fetch_fifo
   import rv32_pkg::*;
#(
   parameter int DEPTH = FETCH_BUF_DEPTH_DEF,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter int CW = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_entry_t mem [DEPTH];
   fetch_entry_t head_reg, head_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next, rd_ptr_inc;
   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic do_push, do_pop;

   assign do_push = push & ~flush & (count_reg != FULL);
   assign do_pop = pop & ~flush & (count_reg != '0);
   assign rd_ptr_inc = rd_ptr_reg + 1'b1;

   // The head register always mirrors the oldest entry, so the consumer never sees a RAM read.
   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next = count_reg;
      head_next = head_reg;
      if (flush) begin
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         count_next = '0;
      end else begin
         if (do_pop)
            rd_ptr_next = rd_ptr_inc;
         if (do_push)
            wr_ptr_next = wr_ptr_reg + 1'b1;
         count_next = count_reg + CW'(do_push) - CW'(do_pop);
         if (do_pop) begin
            if (count_reg > CW'(1))
               head_next = mem[rd_ptr_inc];
            else if (do_push)
               head_next = push_data;
         end else if (do_push && (count_reg == '0)) begin
            head_next = push_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg <= '0;
         head_reg <= '{pc: RESET_PC, word: INSTR_NOP};
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         count_reg <= count_next;
         head_reg <= head_next;
      end
   end

   assign head = head_reg;
   assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC, imem request/response tracking, instruction buffer, redirects.
// Optional misaligned-redirect trap is compiled in with `define FETCH_MISALIGN_CHK_EN.
module fetch_unit
   import rv32_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter int BUF_DEPTH = FETCH_BUF_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            jmp_valid,
   input  logic [XLEN-1:0] jmp_target,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] prog,
   output logic [XLEN-1:0] inst_pc,
   output logic            misalign
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(BUF_DEPTH);

   logic [XLEN-1:0] fetch_pc_reg, rsp_pc_reg, target;
   logic [CW-1:0] outstanding_reg, outstanding_next, drop_cnt_reg, count;
   logic [CW:0] occupancy;
   logic req_fire, rsp_fire, keep, pop, halt;
   fetch_entry_t head, push_data;

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         misalign_reg <= 1'b0;
      else if (jmp_valid && (jmp_target[1:0] != 2'b00))
         misalign_reg <= 1'b1;
   end

   assign halt = misalign_reg;
   assign misalign = misalign_reg;
`else
   assign halt = 1'b0;
   assign misalign = 1'b0;
`endif

   assign target = jmp_target & ~32'h3;
   assign pop = inst_valid & inst_ready;

   // Count every word that will need a slot: in flight plus buffered, net of this cycle's pop.
   assign occupancy = {1'b0, outstanding_reg} + {1'b0, count} - {{CW{1'b0}}, pop};
   assign imem_req_valid = rst_n & ~halt & (occupancy < DEPTH_LIM);
   assign imem_req_addr = fetch_pc_reg;

   assign req_fire = imem_req_valid & imem_req_ready;
   // Responses with nothing outstanding belong to a pre-reset request and are ignored.
   assign rsp_fire = imem_rsp_valid & (outstanding_reg != '0);
   assign keep = rsp_fire & ~jmp_valid & (drop_cnt_reg == '0);
   assign push_data = '{pc: rsp_pc_reg, word: imem_rsp_data};
   assign outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_fire);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_reg <= RESET_PC;
         rsp_pc_reg <= RESET_PC;
         outstanding_reg <= '0;
         drop_cnt_reg <= '0;
      end else begin
         outstanding_reg <= outstanding_next;
         if (jmp_valid) begin
            // Everything still in flight after this edge predates the redirect.
            fetch_pc_reg <= target;
            rsp_pc_reg <= target;
            drop_cnt_reg <= outstanding_next;
         end else begin
            if (req_fire)
               fetch_pc_reg <= pc_inc(fetch_pc_reg);
            if (rsp_fire) begin
               if (drop_cnt_reg != '0)
                  drop_cnt_reg <= drop_cnt_reg - 1'b1;
               else
                  rsp_pc_reg <= pc_inc(rsp_pc_reg);
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH    (BUF_DEPTH),
      .RESET_PC (RESET_PC),
      .CW       (CW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (jmp_valid),
      .push      (keep),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   assign inst_valid = (count != '0);
   assign prog = head.word;
   assign inst_pc = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level model of the delivered instruction stream.
module tb_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid, imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        jmp_valid = 1'b0;
   logic [31:0] jmp_target = '0;
   logic        inst_valid, inst_ready = 1'b0;
   logic [31:0] prog, inst_pc;
   logic        misalign;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .jmp_valid      (jmp_valid),
      .jmp_target     (jmp_target),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .prog           (prog),
      .inst_pc        (inst_pc),
      .misalign       (misalign)
   );

   typedef struct {
      logic [31:0] addr;
      int          tag;
      int          due;
   } mreq_t;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int epoch = 0;
   int mem_lat = 1;
   mreq_t mq[$];
   logic [31:0] q[$];
   logic [31:0] fire_log[$];
   logic [31:0] pop_log[$];
   int pop_cyc[$];
   logic [31:0] exp_addr = '0;
   bit halted = 0;
   bit exp_mis = 0;
   bit last_rv, last_rf, last_req_valid, last_mis;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: drive inputs at negedge, compare against the model, then advance the model.
   task automatic cycle(input bit jv, input logic [31:0] jt, input bit ir, input bit rr);
      bit rv, rf, pp;
      logic [31:0] rd;
      int rtag;
      @(negedge clk);
      rv = 0; rd = '0; rtag = -1;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         rv = 1; rd = mq[0].addr; rtag = mq[0].tag;
         void'(mq.pop_front());
      end
      imem_rsp_valid = rv; imem_rsp_data = rd;
      jmp_valid = jv; jmp_target = jt;
      inst_ready = ir; imem_req_ready = rr;
      #1;
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
         chk("inst_pc", inst_pc, q[0]);
         chk("prog", prog, q[0]);
      end
      chk("misalign", {31'b0, misalign}, {31'b0, exp_mis});
      if (halted)
         chk("req_halted", {31'b0, imem_req_valid}, 32'd0);
      if (imem_req_valid)
         chk("req_addr", imem_req_addr, exp_addr);
      rf = imem_req_valid & rr;
      pp = inst_valid & ir;
      last_rv = rv; last_rf = rf; last_req_valid = imem_req_valid; last_mis = misalign;
      if (pp && !jv) begin
         pop_log.push_back(inst_pc);
         pop_cyc.push_back(cyc);
         if (q.size() != 0) void'(q.pop_front());
      end
      if (rf) begin
         fire_log.push_back(imem_req_addr);
         mq.push_back('{imem_req_addr, epoch, cyc + mem_lat});
         exp_addr = imem_req_addr + 32'd4;
      end
      if (rv && !jv && rtag == epoch)
         q.push_back(rd);
      if (jv) begin
         q.delete();
         epoch++;
         exp_addr = jt & ~32'h3;
`ifdef FETCH_MISALIGN_CHK_EN
         if (jt[1:0] != 2'b00) begin
            halted = 1;
            exp_mis = 1;
         end
`endif
      end
      cyc++;
   endtask

   task automatic run(input int n, input bit ir, input bit rr);
      for (int i = 0; i < n; i++) cycle(0, '0, ir, rr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      imem_req_ready = 0; imem_rsp_valid = 0; jmp_valid = 0; inst_ready = 0;
      #1;
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_prog", prog, 32'h0000_0013);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_misalign", {31'b0, misalign}, 32'd0);
      @(negedge clk);
      q.delete(); mq.delete(); epoch++;
      exp_addr = '0; halted = 0; exp_mis = 0;
      rst_n = 1;
      #1;
      chk("rel_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("rel_req_addr", imem_req_addr, 32'h0);
      fire_log.delete(); pop_log.delete(); pop_cyc.delete();
   endtask

   initial begin
      // Streaming from reset: one instruction per cycle.
      do_reset();
      run(8, 1, 1);
      chk("stream_pops", pop_log.size(), 6);
      if (pop_log.size() >= 3) begin
         chk("stream_pc0", pop_log[0], 32'h0);
         chk("stream_pc1", pop_log[1], 32'h4);
         chk("stream_pc2", pop_log[2], 32'h8);
         chk("stream_gap1", pop_cyc[1] - pop_cyc[0], 1);
         chk("stream_gap2", pop_cyc[2] - pop_cyc[1], 1);
      end
      $display("[TB] stream: %0d pops, first pc %h", pop_log.size(), pop_log.size() ? pop_log[0] : 32'hx);

      // Decoder stalled: only BUF_DEPTH requests may go out.
      do_reset();
      run(10, 0, 1);
      chk("stall_fires", fire_log.size(), DEPTH);
      chk("stall_req_valid", {31'b0, last_req_valid}, 32'd0);
      pop_log.delete();
      run(10, 1, 1);
      if (pop_log.size() >= 3) begin
         chk("resume_pc0", pop_log[0], 32'h0);
         chk("resume_pc1", pop_log[1], 32'h4);
         chk("resume_pc2", pop_log[2], 32'h8);
      end else chk("resume_pops", pop_log.size(), 3);
      $display("[TB] stall: %0d fires, resume %0d pops", DEPTH, pop_log.size());

      // Two requests in flight when the redirect arrives.
      do_reset();
      mem_lat = 2;
      cycle(0, '0, 1, 1);
      cycle(1, 32'h100, 1, 1);
      chk("inflight_fires", fire_log.size(), 2);
      pop_log.delete();
      run(10, 1, 1);
      chk("inflight_first_pc", pop_log.size() ? pop_log[0] : 32'hx, 32'h100);
      $display("[TB] redirect with 2 in flight: first pc %h", pop_log.size() ? pop_log[0] : 32'hx);

      // Redirect coinciding with a response and a request fire.
      do_reset();
      mem_lat = 1;
      run(5, 1, 1);
      cycle(1, 32'h200, 1, 1);
      chk("coinc_rsp", {31'b0, last_rv}, 32'd1);
      chk("coinc_fire", {31'b0, last_rf}, 32'd1);
      pop_log.delete();
      run(6, 1, 1);
      chk("coinc_first_pc", pop_log.size() ? pop_log[0] : 32'hx, 32'h200);
      $display("[TB] redirect with rsp+fire: first pc %h", pop_log.size() ? pop_log[0] : 32'hx);

      // PC wrap across the top of the address space.
      cycle(1, 32'hFFFF_FFF8, 1, 1);
      fire_log.delete();
      run(6, 1, 1);
      if (fire_log.size() >= 3) begin
         chk("wrap_a0", fire_log[0], 32'hFFFF_FFF8);
         chk("wrap_a1", fire_log[1], 32'hFFFF_FFFC);
         chk("wrap_a2", fire_log[2], 32'h0000_0000);
      end else chk("wrap_fires", fire_log.size(), 3);
      $display("[TB] wrap: %0d fires after redirect", fire_log.size());

      // Randomised handshakes and redirects, two-cycle memory.
      do_reset();
      mem_lat = 2;
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 11) == 0)
            cycle(1, 32'($urandom_range(0, 1023)) << 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else
            cycle(0, '0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      end
      $display("[TB] random: %0d pops", pop_log.size());

      // Reset in the middle of a stream.
      do_reset();
      mem_lat = 1;
      run(4, 1, 1);
      do_reset();
      run(6, 1, 1);
      chk("rstmid_first_pc", pop_log.size() ? pop_log[0] : 32'hx, 32'h0);
      $display("[TB] mid-stream reset: first pc %h", pop_log.size() ? pop_log[0] : 32'hx);

      // Misaligned redirect target.
      run(3, 1, 1);
      cycle(1, 32'h102, 1, 1);
      fire_log.delete(); pop_log.delete();
      run(8, 1, 1);
`ifdef FETCH_MISALIGN_CHK_EN
      chk("mis_flag", {31'b0, last_mis}, 32'd1);
      chk("mis_fires", fire_log.size(), 0);
      chk("mis_pops", pop_log.size(), 0);
`else
      chk("mis_flag", {31'b0, last_mis}, 32'd0);
      chk("mis_first_pc", pop_log.size() ? pop_log[0] : 32'hx, 32'h100);
`endif
      $display("[TB] misaligned redirect: misalign %0d, %0d fires", last_mis, fire_log.size());

      do_reset();
      run(3, 1, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
